// File: rtl/calc_mem_io_if.sv
// Core data-port bundle between the arm core and the calc_mem_io stage.
// The core drives address/data/write-enable and receives combinational read data.
interface calc_mem_io_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  modport master (output mem_addr, output mem_wdata, output mem_we, input mem_rdata);
  modport slave  (input mem_addr, input mem_wdata, input mem_we, output mem_rdata);
endinterface

// File: rtl/calc_mem_io.sv
// Calculator data-memory / I/O stage: operand entry FSM, operand/result map, word RAM.
// Optional run-time watchdog is enabled by defining WATCHDOG_EN.
module calc_mem_io #(
  parameter int unsigned RAM_WORDS = 64,
  parameter int unsigned IN_W      = 4,
  parameter logic [31:0] IN_BASE   = 32'h100,
  parameter logic [31:0] RES_ADDR  = 32'h200,
  parameter int unsigned WDOG_CYC  = 1024
) (
  input  logic                clk,
  input  logic                reset_n,
  calc_mem_io_if.slave        mem,
  input  logic [IN_W-1:0]     sw_in,
  input  logic                btn_enter,
  output logic                cpu_run,
  output logic [2:0]          entry_state,
  output logic [31:0]         result_out,
  output logic                result_valid,
  output logic                wdog_err
);

  localparam logic [2:0] ENTER_A  = 3'd0;
  localparam logic [2:0] ENTER_B  = 3'd1;
  localparam logic [2:0] ENTER_OP = 3'd2;
  localparam logic [2:0] RUN      = 3'd3;
  localparam logic [2:0] SHOW     = 3'd4;

  localparam int unsigned AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam logic [31:0] NUM2_ADDR = IN_BASE + 32'd4;
  localparam logic [31:0] OP_ADDR   = IN_BASE + 32'd8;
  localparam logic [29:0] NUM1_WORD = IN_BASE[31:2];
  localparam logic [29:0] NUM2_WORD = NUM2_ADDR[31:2];
  localparam logic [29:0] OP_WORD   = OP_ADDR[31:2];
  localparam logic [29:0] RES_WORD  = RES_ADDR[31:2];
  localparam logic [29:0] RAM_LIMIT = 30'(RAM_WORDS);

  logic [2:0]  state;
  logic [31:0] num1, num2, op;
  logic        btn_s1, btn_s2, btn_prev;
  logic        enter_evt;
  logic        res_store;
  logic [29:0] addr_w;
  logic        ram_hit;
  logic [31:0] ram [RAM_WORDS];
  logic        unused_byte_sel;
  logic        wdog_trip;

  assign addr_w          = mem.mem_addr[31:2];
  assign unused_byte_sel = ^mem.mem_addr[1:0];
  assign ram_hit         = (addr_w < RAM_LIMIT);
  assign enter_evt       = btn_s2 & ~btn_prev;
  assign res_store       = mem.mem_we && (addr_w == RES_WORD) && (state == RUN);
  assign cpu_run         = (state == RUN);
  assign entry_state     = state;

`ifdef WATCHDOG_EN
  logic [31:0] wdog_cnt;

  // The trip lands on the WDOG_CYC-th RUN cycle; a same-cycle result store takes priority.
  assign wdog_trip = (state == RUN) && !res_store && (wdog_cnt == 32'(WDOG_CYC - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdog_cnt <= '0;
      wdog_err <= 1'b0;
    end else begin
      if (state == ENTER_OP && enter_evt)
        wdog_cnt <= '0;
      else if (state == RUN)
        wdog_cnt <= wdog_cnt + 32'd1;
      if (wdog_trip)
        wdog_err <= 1'b1;
    end
  end
`else
  localparam int unsigned unused_wdog_cyc = WDOG_CYC;
  assign wdog_trip = 1'b0;
  assign wdog_err  = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ENTER_A;
      num1         <= '0;
      num2         <= '0;
      op           <= '0;
      result_out   <= '0;
      result_valid <= 1'b0;
      btn_s1       <= 1'b0;
      btn_s2       <= 1'b0;
      btn_prev     <= 1'b0;
    end else begin
      btn_s1       <= btn_enter;
      btn_s2       <= btn_s1;
      btn_prev     <= btn_s2;
      result_valid <= 1'b0;
      case (state)
        ENTER_A: if (enter_evt) begin
          num1  <= 32'(sw_in);
          state <= ENTER_B;
        end
        ENTER_B: if (enter_evt) begin
          num2  <= 32'(sw_in);
          state <= ENTER_OP;
        end
        ENTER_OP: if (enter_evt) begin
          op    <= {30'b0, sw_in[1:0]};
          state <= RUN;
        end
        RUN: begin
          // Enter events are ignored here, so a coincident store simply wins.
          if (res_store) begin
            result_out   <= mem.mem_wdata;
            result_valid <= 1'b1;
            state        <= SHOW;
          end else if (wdog_trip) begin
            result_out   <= 32'hDEAD_DEAD;
            result_valid <= 1'b1;
            state        <= SHOW;
          end
        end
        SHOW: if (enter_evt) state <= ENTER_A;
        default: state <= ENTER_A;
      endcase
    end
  end

  // RAM has no reset: contents survive reset_n.
  always_ff @(posedge clk) begin
    if (mem.mem_we && ram_hit)
      ram[addr_w[AW-1:0]] <= mem.mem_wdata;
  end

  always_comb begin
    mem.mem_rdata = '0;
    if (addr_w == NUM1_WORD)      mem.mem_rdata = num1;
    else if (addr_w == NUM2_WORD) mem.mem_rdata = num2;
    else if (addr_w == OP_WORD)   mem.mem_rdata = op;
    else if (addr_w == RES_WORD)  mem.mem_rdata = result_out;
    else if (ram_hit)             mem.mem_rdata = ram[addr_w[AW-1:0]];
  end

endmodule
